// File: rtl/data_path.sv
// Teaching-CPU register-transfer datapath: one 32-bit bus, 16-entry register file,
// PC/IR/MAR/MDR, Y/Z ALU staging, HI/LO and a 64-bit-result ALU.
module data_path (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        MDRin,
    input  logic        Zin,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic        Read,
    input  logic        IncPC,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        AND,
    input  logic        OR,
    input  logic        MUL,
    input  logic        DIV,
    input  logic [31:0] MDatain,
    input  logic [31:0] InPort,
    output logic [31:0] BusMuxOut,
    output logic [31:0] MARout_q,
    output logic [31:0] IR_q
);

    logic [15:0] rin, rout;
    logic [31:0] rf [16];
    logic [31:0] pc, ir, mar, mdr, y, hi, lo;
    logic [63:0] z, alu_res;
    logic [31:0] bus, c_sext;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign c_sext = {{13{ir[18]}}, ir[18:0]};

    // Priority is realised by assigning lowest-priority sources first, so the
    // last matching assignment (R0 being the very last) wins.
    always_comb begin
        bus = '0;
        if (Cout)      bus = c_sext;
        if (InPortout) bus = InPort;
        if (Zlowout)   bus = z[31:0];
        if (Zhighout)  bus = z[63:32];
        if (LOout)     bus = lo;
        if (HIout)     bus = hi;
        if (MDRout)    bus = mdr;
        if (PCout)     bus = pc;
        for (int unsigned i = 0; i < 16; i++) begin
            if (rout[15 - i]) bus = rf[15 - i];
        end
    end

    logic signed [31:0] div_a, div_b, div_q, div_r;
    logic               div_zero, div_ovf;

    always_comb begin
        div_zero = (bus == '0);
        div_ovf  = (y == 32'h8000_0000) && (bus == '1);
        div_a    = $signed(y);
        // Divisor is forced to 1 in the two special cases so the divider itself
        // never sees a zero divisor or the one overflowing quotient.
        div_b    = (div_zero || div_ovf) ? 32'sd1 : $signed(bus);
        div_q    = div_a / div_b;
        div_r    = div_a % div_b;

        alu_res = {32'd0, bus};
        if (IncPC)    alu_res = {32'd0, bus + 32'd1};
        else if (ADD) alu_res = {32'd0, y + bus};
        else if (SUB) alu_res = {32'd0, y - bus};
        else if (AND) alu_res = {32'd0, y & bus};
        else if (OR)  alu_res = {32'd0, y | bus};
        else if (MUL) alu_res = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
        else if (DIV) begin
            if (div_zero)     alu_res = {y, 32'hFFFF_FFFF};
            else if (div_ovf) alu_res = {32'd0, 32'h8000_0000};
            else              alu_res = {div_r, div_q};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
            z   <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (rin[i]) rf[i] <= bus;
            end
            if (PCin)  pc  <= bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (Yin)   y   <= bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (MDRin) mdr <= Read ? MDatain : bus;
            if (Zin)   z   <= alu_res;
        end
    end

    assign BusMuxOut = bus;
    assign MARout_q  = mar;
    assign IR_q      = ir;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed microstep sequences plus random
// ALU operations checked against an arithmetic reference model.
module tb_data_path;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] rin, rout;
    logic [6:0]  dsts;   // 0 PCin 1 IRin 2 MARin 3 MDRin 4 Yin 5 HIin 6 LOin
    logic [7:0]  srcs;   // 0 PC 1 MDR 2 HI 3 LO 4 Zhigh 5 Zlow 6 InPort 7 C
    logic [6:0]  ops;    // 0 IncPC 1 ADD 2 SUB 3 AND 4 OR 5 MUL 6 DIV
    logic        Zin, Read;
    logic [31:0] MDatain, InPort;
    logic [31:0] BusMuxOut, MARout_q, IR_q;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    data_path dut (
        .clk(clk), .clr(clr),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .PCin(dsts[0]), .IRin(dsts[1]), .MARin(dsts[2]), .MDRin(dsts[3]),
        .Yin(dsts[4]), .HIin(dsts[5]), .LOin(dsts[6]), .Zin(Zin),
        .PCout(srcs[0]), .MDRout(srcs[1]), .HIout(srcs[2]), .LOout(srcs[3]),
        .Zhighout(srcs[4]), .Zlowout(srcs[5]), .InPortout(srcs[6]), .Cout(srcs[7]),
        .Read(Read),
        .IncPC(ops[0]), .ADD(ops[1]), .SUB(ops[2]), .AND(ops[3]),
        .OR(ops[4]), .MUL(ops[5]), .DIV(ops[6]),
        .MDatain(MDatain), .InPort(InPort),
        .BusMuxOut(BusMuxOut), .MARout_q(MARout_q), .IR_q(IR_q)
    );

    // Reference ALU: Z = {Zhigh, Zlow} from the operation rules, using 64-bit arithmetic.
    function automatic logic [63:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0: return {32'd0, b + 32'd1};
            1: return {32'd0, a + b};
            2: return {32'd0, a - b};
            3: return {32'd0, a & b};
            4: return {32'd0, a | b};
            5: begin p = sa * sb; return p; end
            6: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {32'd0, b};
        endcase
    endfunction

    task automatic clear_strobes;
        rin = '0; rout = '0; dsts = '0; srcs = '0; ops = '0; Zin = 1'b0; Read = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    // src: 0..15 = Rn, 16 PC, 17 MDR, 18 HI, 19 LO, 20 Zhigh, 21 Zlow, 22 InPort, 23 C
    task automatic read_src(input int src, output logic [31:0] v);
        if (src < 16) rout[src] = 1'b1;
        else          srcs[src - 16] = 1'b1;
        #1;
        v = BusMuxOut;
        rout = '0;
        srcs = '0;
        #1;
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        MDatain = val; Read = 1'b1; dsts[3] = 1'b1;
        tick();
        srcs[1] = 1'b1; rin[idx] = 1'b1;
        tick();
    endtask

    task automatic alu_run(input int op, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] zv);
        logic [31:0] lo_v, hi_v;
        load_reg(4, a);
        load_reg(5, b);
        rout[4] = 1'b1; dsts[4] = 1'b1;
        tick();
        rout[5] = 1'b1; Zin = 1'b1;
        if (op < 7) ops[op] = 1'b1;
        tick();
        read_src(21, lo_v);
        read_src(20, hi_v);
        zv = {hi_v, lo_v};
    endtask

    task automatic move_z_to_lohi;
        srcs[5] = 1'b1; dsts[6] = 1'b1;
        tick();
        srcs[4] = 1'b1; dsts[5] = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [31:0] v;
        read_src(16, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL por_pc: got %h expected 0", v); end
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        load_reg(1, 32'h55);
        load_reg(15, 32'hAA);
        MDatain = 32'hC0DE; Read = 1'b1; dsts[3] = 1'b1;
        tick();
        srcs[1] = 1'b1; dsts = 7'b1110111; Zin = 1'b1;
        tick();
        checks++; if (MARout_q !== 32'hC0DE) begin fails++; $display("FAIL multi_in_mar: got %h expected c0de", MARout_q); end
        checks++; if (IR_q !== 32'hC0DE) begin fails++; $display("FAIL multi_in_ir: got %h expected c0de", IR_q); end
        read_src(18, v);
        checks++; if (v !== 32'hC0DE) begin fails++; $display("FAIL multi_in_hi: got %h expected c0de", v); end
        read_src(1, v);
        checks++; if (v !== 32'h55) begin fails++; $display("FAIL pre_reset_r1: got %h expected 55", v); end
        InPort = 32'd0;
        #2; clr = 1'b0; #1;
        checks++; if (MARout_q !== 32'd0) begin fails++; $display("FAIL reset_mar: got %h expected 0", MARout_q); end
        checks++; if (IR_q !== 32'd0) begin fails++; $display("FAIL reset_ir: got %h expected 0", IR_q); end
        for (int i = 0; i < 24; i++) begin
            read_src(i, v);
            checks++; if (v !== 32'd0) begin fails++; $display("FAIL reset_src%0d: got %h expected 0", i, v); end
        end
        @(negedge clk); clr = 1'b1; #1;
        read_src(16, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL post_reset_pc: got %h expected 0", v); end
        InPort = 32'h1234; srcs[6] = 1'b1; ops[1] = 1'b1; Zin = 1'b1;
        tick();
        read_src(21, v);
        checks++; if (v !== 32'h1234) begin fails++; $display("FAIL reset_y: got %h expected 1234", v); end
    endtask

    task automatic test_load_transfer;
        logic [31:0] v;
        MDatain = 32'h12; Read = 1'b1; dsts[3] = 1'b1;
        tick();
        read_src(17, v);
        checks++; if (v !== 32'h12) begin fails++; $display("FAIL mdr_read: got %h expected 12", v); end
        srcs[1] = 1'b1; rin[2] = 1'b1;
        tick();
        read_src(2, v);
        checks++; if (v !== 32'h12) begin fails++; $display("FAIL r2_xfer: got %h expected 12", v); end
        load_reg(3, 32'h14);
        load_reg(1, 32'h18);
        read_src(3, v);
        checks++; if (v !== 32'h14) begin fails++; $display("FAIL r3_xfer: got %h expected 14", v); end
        read_src(1, v);
        checks++; if (v !== 32'h18) begin fails++; $display("FAIL r1_xfer: got %h expected 18", v); end
        InPort = 32'h77; MDatain = 32'hDEAD; srcs[6] = 1'b1; dsts[3] = 1'b1; Read = 1'b0;
        tick();
        read_src(17, v);
        checks++; if (v !== 32'h77) begin fails++; $display("FAIL mdr_from_bus: got %h expected 77", v); end
    endtask

    task automatic test_fetch;
        logic [31:0] v;
        srcs[0] = 1'b1; dsts[2] = 1'b1; ops[0] = 1'b1; Zin = 1'b1;
        tick();
        checks++; if (MARout_q !== 32'd0) begin fails++; $display("FAIL t0_mar: got %h expected 0", MARout_q); end
        read_src(21, v);
        checks++; if (v !== 32'd1) begin fails++; $display("FAIL t0_zlow: got %h expected 1", v); end
        srcs[5] = 1'b1; dsts[0] = 1'b1; Read = 1'b1; dsts[3] = 1'b1; MDatain = 32'h2891_8000;
        tick();
        read_src(16, v);
        checks++; if (v !== 32'd1) begin fails++; $display("FAIL t1_pc: got %h expected 1", v); end
        read_src(17, v);
        checks++; if (v !== 32'h2891_8000) begin fails++; $display("FAIL t1_mdr: got %h expected 28918000", v); end
        srcs[1] = 1'b1; dsts[1] = 1'b1;
        tick();
        checks++; if (IR_q !== 32'h2891_8000) begin fails++; $display("FAIL t2_ir: got %h expected 28918000", IR_q); end
        read_src(23, v);
        checks++; if (v !== 32'h0001_8000) begin fails++; $display("FAIL c_pos: got %h expected 00018000", v); end
        MDatain = 32'h0004_0005; Read = 1'b1; dsts[3] = 1'b1;
        tick();
        srcs[1] = 1'b1; dsts[1] = 1'b1;
        tick();
        read_src(23, v);
        checks++; if (v !== 32'hFFFC_0005) begin fails++; $display("FAIL c_neg: got %h expected fffc0005", v); end
    endtask

    task automatic test_div;
        logic [31:0] a_t [4] = '{32'd2, 32'hFFFF_FFF9, 32'd2, 32'h8000_0000};
        logic [31:0] b_t [4] = '{32'hFFFF_FFF6, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] lo_t [4] = '{32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] hi_t [4] = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'd0};
        logic [63:0] zv;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            alu_run(6, a_t[i], b_t[i], zv);
            move_z_to_lohi();
            read_src(19, v);
            checks++; if (v !== lo_t[i]) begin fails++; $display("FAIL div%0d_lo: got %h expected %h", i, v, lo_t[i]); end
            read_src(18, v);
            checks++; if (v !== hi_t[i]) begin fails++; $display("FAIL div%0d_hi: got %h expected %h", i, v, hi_t[i]); end
        end
    endtask

    task automatic test_mul_add;
        int          op_t [7] = '{5, 5, 1, 2, 3, 4, 0};
        logic [31:0] a_t [7]  = '{32'h12, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'hF0F0, 32'hF000, 32'd9};
        logic [31:0] b_t [7]  = '{32'h14, 32'd5, 32'd1, 32'd7, 32'hFF00, 32'h000F, 32'hFFFF_FFFF};
        logic [63:0] z_t [7]  = '{64'h168, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 64'h0000_0000_FFFF_FFFE,
                                  64'hF000, 64'hF00F, 64'd0};
        logic [63:0] zv;
        for (int i = 0; i < 7; i++) begin
            alu_run(op_t[i], a_t[i], b_t[i], zv);
            checks++; if (zv !== z_t[i]) begin fails++; $display("FAIL alu%0d_op%0d: got %h expected %h", i, op_t[i], zv, z_t[i]); end
        end
    endtask

    task automatic test_priority;
        logic [31:0] v;
        load_reg(2, 32'd5);
        MDatain = 32'd9; Read = 1'b1; dsts[3] = 1'b1;
        tick();
        rout[2] = 1'b1; srcs[1] = 1'b1; #1;
        checks++; if (BusMuxOut !== 32'd5) begin fails++; $display("FAIL prio_r2_mdr: got %h expected 5", BusMuxOut); end
        rout = '0; srcs[2] = 1'b1; #1;
        checks++; if (BusMuxOut !== 32'd9) begin fails++; $display("FAIL prio_mdr_hi: got %h expected 9", BusMuxOut); end
        srcs = '0; #1;
        checks++; if (BusMuxOut !== 32'd0) begin fails++; $display("FAIL bus_idle: got %h expected 0", BusMuxOut); end
        read_src(2, v);
        checks++; if (v !== 32'd5) begin fails++; $display("FAIL r2_value: got %h expected 5", v); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        rout[2] = 1'b1; rin[2] = 1'b1;
        tick();
        read_src(2, v);
        checks++; if (v !== 32'd5) begin fails++; $display("FAIL self_reload: got %h expected 5", v); end
        srcs[1] = 1'b1; rin[6] = 1'b1; rin[7] = 1'b1;
        tick();
        rout[6] = 1'b1; rin[8] = 1'b1;
        tick();
        read_src(7, v);
        checks++; if (v !== 32'd9) begin fails++; $display("FAIL dual_in_r7: got %h expected 9", v); end
        read_src(8, v);
        checks++; if (v !== 32'd9) begin fails++; $display("FAIL chain_r8: got %h expected 9", v); end
    endtask

    task automatic test_random;
        logic [31:0] special [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        logic [31:0] a, b;
        logic [63:0] zv, exp_z;
        int          op;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            if (op == 6 && $urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            exp_z = ref_alu(op, a, b);
            alu_run(op, a, b, zv);
            checks++;
            if (zv !== exp_z) begin
                fails++;
                $display("FAIL rand%0d op%0d a=%h b=%h: got %h expected %h", i, op, a, b, zv, exp_z);
            end
        end
    endtask

    initial begin
        clear_strobes();
        clr = 1'b0;
        MDatain = '0;
        InPort = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_transfer();
        test_fetch();
        test_div();
        test_mul_add();
        test_priority();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Register-transfer datapath for the teaching CPU. It provides a single 32-bit internal bus, a 16-entry register file, PC, IR, MAR and MDR, the Y/Z ALU staging registers, HI/LO, and a 64-bit-result ALU. The external control unit or testbench drives one-hot "out" and "in" strobes for each microstep (T0–T6), so every transfer or ALU step takes one clock.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all registers load on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- R0in..R15in  in  1 each  load register Rn from the bus.
- R0out..R15out  in  1 each  drive Rn onto the bus.
- PCin, IRin, MARin, Yin, HIin, LOin  in  1 each  load from the bus.
- MDRin  in  1  load MDR.
- Zin  in  1  load the 64-bit Z register with the ALU result.
- PCout, MDRout, HIout, LOout, Zlowout, Zhighout, InPortout, Cout  in  1 each  drive the named source onto the bus.
- Read  in  1  MDR input select: 1 selects MDatain, 0 selects the bus.
- IncPC, ADD, SUB, AND, OR, MUL, DIV  in  1 each  ALU operation select.
- MDatain  in  32  memory read data.
- InPort  in  32  input-port data.
- BusMuxOut  out  32  current bus value.
- MARout_q  out  32  MAR contents (memory address).
- IR_q  out  32  IR contents, for the control unit.

## Operation
Bus multiplexer:
- Combinational.
- When more than one source strobe is high, priority is R0..R15, PC, MDR, HI, LO, Zhigh, Zlow, InPort, C.
- No source strobe high: the bus is 0.
- C is IR[18:0] sign-extended to 32 bits.

Register loading:
- Each register loads from the bus when its in-strobe is high.
- MDR loads (Read ? MDatain : bus) when MDRin is high.

ALU (combinational):
- Operand A is Y; operand B is the bus.
- The result is 64 bits and is written to Z on Zin.
- Operation priority: IncPC > ADD > SUB > AND > OR > MUL > DIV.
- IncPC: Zlow = B + 1, Zhigh = 0.
- ADD, SUB, AND, OR: Zlow = A op B, Zhigh = 0. Arithmetic wraps modulo 2^32.
- MUL: signed 32×32 multiply. Z = full 64-bit product; Zhigh holds the upper word.
- DIV: signed divide, quotient truncated toward zero. Zlow = A / B. Zhigh = remainder, which takes the sign of the dividend A.
- DIV with B = 0: Zlow = 0xFFFFFFFF, Zhigh = A.
- DIV of 0x80000000 by −1: Zlow = 0x80000000, Zhigh = 0.
- No operation selected: Zlow = B, Zhigh = 0.

Reset:
- While clr = 0, every register is 0: R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO.
- Reset asserted mid-sequence clears all state immediately, regardless of the clock.

## Timing
- Every transfer is one cycle: source strobe plus destination strobe high before a rising edge, and the destination holds the new value after that edge.
- ALU latency is 2 cycles.
  - Cycle 1: Yin captures operand A.
  - Cycle 2: source of operand B plus an op strobe plus Zin; Z is valid after the edge.
  - Moving the result out (Zlow → LO, Zhigh → HI) takes 1 cycle each.
- Memory read is 1 cycle: MDatain must be stable before the edge on which Read and MDRin are high.
- Simultaneous in-strobes: every selected destination loads the same bus value on the same edge.
- Simultaneous in and out strobes on one register: it reloads its old value.
- Strobes may change between edges; only their values at the rising edge matter.
- The bus and ALU have no internal state.

## Test plan
- Reset: drive clr = 0 mid-run with registers loaded → all registers read 0 at once. After clr = 1, PCout shows 0 on the bus.
- Load and transfer:
  - MDatain = 0x12 with Read, MDRin → MDR = 0x12.
  - Next cycle MDRout, R2in → R2 = 0x12.
  - Likewise load R3 = 0x14 and R1 = 0x18.
- Fetch: PC = 0.
  - T0: PCout, MARin, IncPC, Zin → MAR = 0, Zlow = 1.
  - T1: Zlowout, PCin, Read, MDRin with MDatain = 0x28918000 → PC = 1, MDR = 0x28918000.
  - T2: MDRout, IRin → IR = 0x28918000.
- Signed DIV:
  - R4 = 2, R5 = −10.
  - R4out, Yin, then R5out, DIV, Zin, then Zlowout, LOin, then Zhighout, HIin → LO = 0, HI = 2.
  - Repeat with −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Repeat with 2 / 0 → LO = 0xFFFFFFFF, HI = 2.
- MUL and ADD/SUB:
  - 0x12 × 0x14 → LO = 0x168, HI = 0.
  - −3 × 5 → LO = 0xFFFFFFF1, HI = 0xFFFFFFFF.
  - 0xFFFFFFFF + 1 via ADD → Zlow = 0.
- Bus priority: assert R2out and MDRout together with R2 = 5, MDR = 9 → bus = 5. No out strobes → bus = 0.
